// File: rtl/nonce_sched_pkg.sv
// Shared types and constants for the nonce scheduler.
package nonce_sched_pkg;

  localparam int HDR_WORDS = 20;
  localparam int HDR_CNT_W = 5;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_SEND  = 3'd3,
    S_RUN   = 3'd4,
    S_DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/nonce_sched_hdr_buf.sv
// 20x32 block-header register file: one write port, one combinational read port.
module nonce_sched_hdr_buf
  import nonce_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr_i,
  input  logic                 we_i,
  input  logic [HDR_CNT_W-1:0] wr_idx_i,
  input  logic [31:0]          wr_data_i,
  input  logic [HDR_CNT_W-1:0] rd_idx_i,
  output logic [31:0]          rd_data_o
);

  logic [31:0] mem_q [HDR_WORDS];

  // Clear on reset or job start, otherwise store one word per write strobe.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      for (int i = 0; i < HDR_WORDS; i++) mem_q[i] <= '0;
    end else if (we_i && (wr_idx_i < HDR_CNT_W'(HDR_WORDS))) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  assign rd_data_o = (rd_idx_i < HDR_CNT_W'(HDR_WORDS)) ? mem_q[rd_idx_i] : '0;

endmodule

// File: rtl/nonce_sched.sv
// Job front-end: loads one header from the host FIFO, splits the nonce range
// across the cores, broadcasts the header and tracks completion or host stop.
//
// Handshakes: the header FIFO is first-word-fall-through; a word is consumed
// on every rising edge where hdr_fifo_re is high, and hdr_fifo_re is only
// raised while hdr_fifo_empty is low. Cores are written one word per cycle
// with core_hdr_we[k] qualifying core_hdr_word; there is no back-pressure.
module nonce_sched
  import nonce_sched_pkg::*;
#(
  parameter int NUM_CORES  = 4,
  parameter int LOG2_CORES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    host_start,
  input  logic                    host_stop,
  input  logic [31:0]             nonce_size_total,
  input  logic [31:0]             hdr_fifo_dout,
  input  logic                    hdr_fifo_empty,
  output logic                    hdr_fifo_re,
  output logic [NUM_CORES-1:0]    core_start,
  output logic                    core_stop,
  output logic [31:0]             core_hdr_word,
  output logic [NUM_CORES-1:0]    core_hdr_we,
  output logic [32*NUM_CORES-1:0] core_nonce_size,
  input  logic [NUM_CORES-1:0]    core_stop_ack,
  output logic                    busy,
  output logic                    done,
  output logic [31:0]             run_cycles
);

  localparam int CW = (LOG2_CORES > 0) ? LOG2_CORES : 1;
  localparam logic [HDR_CNT_W-1:0] LAST_WORD = HDR_CNT_W'(HDR_WORDS - 1);
  localparam logic [CW-1:0]        LAST_CORE = CW'(NUM_CORES - 1);

  state_e                 state_q;
  logic [HDR_CNT_W-1:0]   hdr_cnt_q;
  logic [CW-1:0]          core_idx_q;
  logic [HDR_CNT_W-1:0]   word_idx_q;
  logic [31:0]            total_q;
  logic                   stop_pend_q;
  logic [NUM_CORES-1:0]   seen_low_q;
  logic [NUM_CORES-1:0]   core_start_q;
  logic                   core_stop_q;
  logic [31:0]            core_hdr_word_q;
  logic [NUM_CORES-1:0]   core_hdr_we_q;
  logic [32*NUM_CORES-1:0] core_nonce_size_q;
  logic                   busy_q;
  logic                   done_q;
  logic [31:0]            run_cycles_q;

  logic                   accept;
  logic                   all_done;
  logic                   last_send;
  logic [CW-1:0]          nxt_core;
  logic [HDR_CNT_W-1:0]   nxt_word;
  logic [31:0]            rd_data;
  logic [31:0]            slice;
  logic [31:0]            rem;
  logic [31:0]            send_word;

  assign accept    = host_start && !host_stop && (&core_stop_ack);
  assign all_done  = (&seen_low_q) && (&core_stop_ack);
  assign last_send = (word_idx_q == LAST_WORD) && (core_idx_q == LAST_CORE);
  assign slice     = total_q >> LOG2_CORES;
  assign rem       = total_q & 32'(NUM_CORES - 1);

  // Pop only while loading and data is present.
  assign hdr_fifo_re = (state_q == S_LOAD) && !hdr_fifo_empty;

  // Index of the header word to present on the next cycle.
  always_comb begin
    nxt_core = core_idx_q;
    nxt_word = word_idx_q + HDR_CNT_W'(1);
    if (state_q == S_START) begin
      nxt_core = '0;
      nxt_word = '0;
    end else if (word_idx_q == LAST_WORD) begin
      nxt_core = core_idx_q + CW'(1);
      nxt_word = '0;
    end
  end

  // Word 0 carries each core's start nonce; the rest go out verbatim.
  assign send_word = rd_data + ((nxt_word == '0) ? (32'(nxt_core) * slice) : 32'd0);

  nonce_sched_hdr_buf u_hdr_buf (
    .clk       (clk),
    .rst       (rst),
    .clr_i     ((state_q == S_IDLE) && accept),
    .we_i      (hdr_fifo_re),
    .wr_idx_i  (hdr_cnt_q),
    .wr_data_i (hdr_fifo_dout),
    .rd_idx_i  (nxt_word),
    .rd_data_o (rd_data)
  );

  // Job sequencer with all outputs registered alongside the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q           <= S_IDLE;
      hdr_cnt_q         <= '0;
      core_idx_q        <= '0;
      word_idx_q        <= '0;
      total_q           <= '0;
      stop_pend_q       <= 1'b0;
      seen_low_q        <= '0;
      core_start_q      <= '0;
      core_stop_q       <= 1'b0;
      core_hdr_word_q   <= '0;
      core_hdr_we_q     <= '0;
      core_nonce_size_q <= '0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      run_cycles_q      <= '0;
    end else begin
      core_start_q  <= '0;
      core_hdr_we_q <= '0;
      done_q        <= 1'b0;
      if (state_q != S_IDLE) seen_low_q <= seen_low_q | ~core_stop_ack;
      case (state_q)
        S_IDLE: begin
          if (accept) begin
            total_q      <= nonce_size_total;
            run_cycles_q <= '0;
            hdr_cnt_q    <= '0;
            stop_pend_q  <= 1'b0;
            seen_low_q   <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_LOAD;
          end
        end
        S_LOAD: begin
          if (host_stop) stop_pend_q <= 1'b1;
          if (!hdr_fifo_empty) begin
            hdr_cnt_q <= hdr_cnt_q + HDR_CNT_W'(1);
            if (hdr_cnt_q == LAST_WORD) begin
              core_start_q <= '1;
              for (int k = 0; k < NUM_CORES; k++) begin
                core_nonce_size_q[32*k +: 32] <= (k == NUM_CORES - 1) ? (slice + rem) : slice;
              end
              state_q <= S_START;
            end
          end
        end
        S_START: begin
          if (host_stop) stop_pend_q <= 1'b1;
          core_hdr_we_q   <= NUM_CORES'(1) << nxt_core;
          core_hdr_word_q <= send_word;
          core_idx_q      <= nxt_core;
          word_idx_q      <= nxt_word;
          state_q         <= S_SEND;
        end
        S_SEND: begin
          if (host_stop) stop_pend_q <= 1'b1;
          if (last_send) begin
            if (stop_pend_q || host_stop) begin
              core_stop_q <= 1'b1;
              state_q     <= S_DRAIN;
            end else begin
              state_q <= S_RUN;
            end
          end else begin
            core_hdr_we_q   <= NUM_CORES'(1) << nxt_core;
            core_hdr_word_q <= send_word;
            core_idx_q      <= nxt_core;
            word_idx_q      <= nxt_word;
          end
        end
        S_RUN: begin
          if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 32'd1;
          if (all_done) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (host_stop) begin
            core_stop_q <= 1'b1;
            state_q     <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          if (run_cycles_q != '1) run_cycles_q <= run_cycles_q + 32'd1;
          if (all_done) begin
            core_stop_q <= 1'b0;
            done_q      <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign core_start      = core_start_q;
  assign core_stop       = core_stop_q;
  assign core_hdr_word   = core_hdr_word_q;
  assign core_hdr_we     = core_hdr_we_q;
  assign core_nonce_size = core_nonce_size_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign run_cycles      = run_cycles_q;

endmodule

// File: tb/tb_nonce_sched.sv
// Scoreboard bench for nonce_sched: random jobs, FIFO and core models.
module tb_nonce_sched;

  localparam int NUM_CORES  = 4;
  localparam int LOG2_CORES = 2;
  localparam int SW         = 32 * NUM_CORES;
  localparam int HW         = 20;

  typedef struct {
    int start_cyc;
    int run_entry;
    int stop_rise;
  } job_t;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    host_start = 1'b0;
  logic                    host_stop = 1'b0;
  logic [31:0]             nonce_size_total = '0;
  logic [31:0]             hdr_fifo_dout;
  logic                    hdr_fifo_empty;
  logic                    hdr_fifo_re;
  logic [NUM_CORES-1:0]    core_start;
  logic                    core_stop;
  logic [31:0]             core_hdr_word;
  logic [NUM_CORES-1:0]    core_hdr_we;
  logic [SW-1:0]           core_nonce_size;
  logic [NUM_CORES-1:0]    core_stop_ack = '1;
  logic                    busy;
  logic                    done;
  logic [31:0]             run_cycles;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // header FIFO model
  logic [31:0] fifo_mem [0:1023];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign hdr_fifo_empty = (rd_ptr == wr_ptr);
  assign hdr_fifo_dout  = fifo_mem[rd_ptr];

  // scoreboard queues
  logic [31:0]          exp_word_q[$];
  logic [NUM_CORES-1:0] exp_we_q[$];
  logic [31:0]          exp_size_q[$];
  job_t                 job_q[$];

  // monitor per-job state
  int we_cnt = 0;
  int rise_cyc = -1;
  int re_bad = 0;
  logic prev_stop = 1'b0;
  logic prev_busy = 1'b0;

  // core model state
  int cnt [NUM_CORES];
  int all_high_cyc = 0;
  logic all_prev = 1'b1;

  nonce_sched #(.NUM_CORES(NUM_CORES), .LOG2_CORES(LOG2_CORES)) dut (
    .clk              (clk),
    .rst              (rst),
    .host_start       (host_start),
    .host_stop        (host_stop),
    .nonce_size_total (nonce_size_total),
    .hdr_fifo_dout    (hdr_fifo_dout),
    .hdr_fifo_empty   (hdr_fifo_empty),
    .hdr_fifo_re      (hdr_fifo_re),
    .core_start       (core_start),
    .core_stop        (core_stop),
    .core_hdr_word    (core_hdr_word),
    .core_hdr_we      (core_hdr_we),
    .core_nonce_size  (core_nonce_size),
    .core_stop_ack    (core_stop_ack),
    .busy             (busy),
    .done             (done),
    .run_cycles       (run_cycles)
  );

  // clock / cycle counter / FIFO read pointer
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (hdr_fifo_re === 1'b1) rd_ptr <= rd_ptr + 1;

  task automatic chk(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event missing or unexpected (cycle %0d)", name, cyc);
  endtask

  task automatic fifo_push(input logic [31:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr++;
  endtask

  task automatic flush_sb();
    exp_word_q.delete();
    exp_we_q.delete();
    exp_size_q.delete();
    job_q.delete();
    we_cnt   = 0;
    rise_cyc = -1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_re"},    SW'(hdr_fifo_re), '0);
    chk({tag, "_start"}, SW'(core_start), '0);
    chk({tag, "_stop"},  SW'(core_stop), '0);
    chk({tag, "_we"},    SW'(core_hdr_we), '0);
    chk({tag, "_busy"},  SW'(busy), '0);
    chk({tag, "_done"},  SW'(done), '0);
    chk({tag, "_word"},  SW'(core_hdr_word), '0);
    chk({tag, "_size"},  core_nonce_size, '0);
    chk({tag, "_runc"},  SW'(run_cycles), '0);
  endtask

  // core model: drop ack on start, finish after a random time, finish fast on stop
  always @(negedge clk) begin
    if (rst) begin
      core_stop_ack = '1;
      for (int k = 0; k < NUM_CORES; k++) cnt[k] = 0;
    end else begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (core_start[k]) begin
          core_stop_ack[k] = 1'b0;
          cnt[k] = $urandom_range(100, 200);
        end else if (!core_stop_ack[k]) begin
          if (core_stop && cnt[k] > 3) cnt[k] = $urandom_range(1, 3);
          cnt[k]--;
          if (cnt[k] == 0) core_stop_ack[k] = 1'b1;
        end
      end
      if ((&core_stop_ack) && !all_prev) all_high_cyc = cyc;
    end
    all_prev = &core_stop_ack;
  end

  // monitor: pops expectations whenever the DUT presents an output
  always @(negedge clk) begin
    if (!rst) begin
      if (hdr_fifo_re && hdr_fifo_empty) re_bad++;
      if (core_stop && !prev_stop && rise_cyc < 0) rise_cyc = cyc;
      if (|core_start) begin
        if (job_q.size() == 0) fail_now("unexpected_start");
        else begin
          chk("start_all", SW'(core_start), SW'({NUM_CORES{1'b1}}));
          chk("start_cycle", SW'(cyc), SW'(job_q[0].start_cyc));
          for (int k = 0; k < NUM_CORES; k++) begin
            if (exp_size_q.size() == 0) fail_now("size_queue_empty");
            else chk($sformatf("size_core%0d", k), SW'(core_nonce_size[32*k +: 32]),
                     SW'(exp_size_q.pop_front()));
          end
        end
      end
      if (|core_hdr_we) begin
        if (exp_word_q.size() == 0 || job_q.size() == 0) fail_now("unexpected_we");
        else begin
          if (we_cnt == 0) chk("first_we_cycle", SW'(cyc), SW'(job_q[0].start_cyc + 1));
          chk("hdr_word", SW'(core_hdr_word), SW'(exp_word_q.pop_front()));
          chk("hdr_we", SW'(core_hdr_we), SW'(exp_we_q.pop_front()));
          we_cnt++;
        end
      end
      if (done) begin
        if (job_q.size() == 0) fail_now("unexpected_done");
        else begin
          job_t j;
          int dexp;
          j = job_q.pop_front();
          dexp = ((all_high_cyc > j.run_entry) ? all_high_cyc : j.run_entry) + 1;
          chk("done_cycle", SW'(cyc), SW'(dexp));
          chk("run_cycles", SW'(run_cycles), SW'(dexp - j.run_entry));
          chk("done_busy", SW'(busy), '0);
          chk("done_busy_prev", SW'(prev_busy), SW'(1));
          chk("we_count", SW'(we_cnt), SW'(HW * NUM_CORES));
          chk("stop_rise", SW'(rise_cyc), SW'(j.stop_rise));
          if (j.stop_rise >= 0) begin
            chk("stop_held", SW'(prev_stop), SW'(1));
            chk("stop_dropped", SW'(core_stop), '0);
          end
          we_cnt   = 0;
          rise_cyc = -1;
        end
      end
    end
    prev_stop = core_stop;
    prev_busy = busy;
  end

  // mode: 0 plain, 1 stop during LOAD, 2 stop during RUN, 3 reset during SEND
  task automatic run_job(input logic [31:0] total, input logic [31:0] base, input int gap,
                         input int mode, input bit both_first);
    logic [31:0] hdr [HW];
    logic [31:0] slice;
    logic [31:0] rem;
    int a, n0, tmo, rptr0;
    job_t j;
    hdr[0] = base;
    for (int i = 1; i < HW; i++) hdr[i] = $urandom();
    tmo = 0;
    while ((busy !== 1'b0 || core_stop_ack !== '1) && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 3000) fail_now("idle_wait_timeout");
    n0 = (gap > 0) ? 7 : HW;
    for (int i = 0; i < n0; i++) fifo_push(hdr[i]);
    nonce_size_total = total;
    if (both_first) begin
      rptr0 = rd_ptr;
      host_start = 1'b1;
      host_stop  = 1'b1;
      repeat (3) begin
        @(negedge clk);
        chk("both_busy", SW'(busy), '0);
        chk("both_re", SW'(hdr_fifo_re), '0);
      end
      chk("both_no_pop", SW'(rd_ptr), SW'(rptr0));
      host_start = 1'b0;
      host_stop  = 1'b0;
    end
    // reference model: split range, per-core start nonces, verbatim header words
    slice = total / 32'(NUM_CORES);
    rem   = total % 32'(NUM_CORES);
    for (int k = 0; k < NUM_CORES; k++) begin
      exp_size_q.push_back((k == NUM_CORES - 1) ? slice + rem : slice);
      for (int w = 0; w < HW; w++) begin
        exp_word_q.push_back((w == 0) ? base + slice * 32'(k) : hdr[w]);
        exp_we_q.push_back(NUM_CORES'(1) << k);
      end
    end
    a = cyc;
    j.start_cyc = a + 21 + gap;
    j.run_entry = a + 22 + gap + HW * NUM_CORES;
    j.stop_rise = (mode == 1) ? j.run_entry : (mode == 2) ? j.run_entry + 6 : -1;
    job_q.push_back(j);
    host_start = 1'b1;
    @(negedge clk);
    host_start = 1'b0;
    if (gap > 0) begin
      repeat (7 + gap) @(negedge clk);
      for (int i = 7; i < HW; i++) fifo_push(hdr[i]);
    end
    if (mode == 1) begin
      repeat (2) @(negedge clk);
      host_stop = 1'b1;
      @(negedge clk);
      host_stop = 1'b0;
    end else if (mode == 2) begin
      while (cyc < j.run_entry + 5) @(negedge clk);
      host_stop = 1'b1;
      @(negedge clk);
      host_stop = 1'b0;
    end else if (mode == 3) begin
      while (cyc < j.start_cyc + 10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_send");
      @(negedge clk);
      rst = 1'b0;
      flush_sb();
      return;
    end
    tmo = 0;
    while (job_q.size() != 0 && tmo < 3000) begin
      @(negedge clk);
      tmo++;
    end
    if (tmo >= 3000) begin
      fail_now("job_done_timeout");
      flush_sb();
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("reset");
    run_job(32'h0000_0400, 32'h1000_0000, 0, 0, 1'b0);
    run_job(32'h0000_0403, $urandom(), 0, 0, 1'b1);
    run_job(32'h0000_0200, 32'hFFFF_FF80, 10, 0, 1'b0);
    run_job($urandom(), $urandom(), 0, 2, 1'b0);
    run_job($urandom(), $urandom(), 0, 1, 1'b0);
    run_job($urandom(), $urandom(), 0, 3, 1'b0);
    for (int r = 0; r < 3; r++) begin
      run_job($urandom(), $urandom(), $urandom_range(0, 4), 0, 1'b0);
    end
    repeat (5) @(negedge clk);
    chk("re_while_empty", SW'(re_bad), '0);
    chk("jobs_left", SW'(job_q.size()), '0);
    chk("words_left", SW'(exp_word_q.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule
